// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/subtract ALU: op encodings and
// the carry-chain segmentation helper.
package alu_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD     = 2'b00;
    localparam op_t OP_SUB     = 2'b01;
    localparam op_t OP_ADD_SAT = 2'b10;
    localparam op_t OP_SUB_SAT = 2'b11;

    // Bit 0 selects subtraction for both the wrapping and saturating forms.
    function automatic logic op_is_sub(op_t op);
        return op[0];
    endfunction

    // Width of carry-chain segment idx when width bits are split into
    // ceil(width/stages)-bit pieces; trailing segments may be short or empty.
    function automatic int unsigned seg_width(int unsigned width, int unsigned stages,
                                              int unsigned idx);
        int unsigned seg;
        int unsigned lo;
        seg = (width + stages - 1) / stages;
        lo  = idx * seg;
        if (lo >= width) begin
            return 0;
        end
        return ((width - lo) < seg) ? (width - lo) : seg;
    endfunction

endpackage

// File: rtl/alu_add_seg.sv
// One carry-chain segment: a plain ripple-carry adder of W bits.
module alu_add_seg #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    // Ripple the carry bit by bit through the segment.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];

endmodule

// File: rtl/alu_add_pipe.sv
// Pipelined add/subtract ALU. The carry chain is cut into STAGES segments,
// one resolved per pipeline stage, with the inter-segment carry, partial sum
// and remaining operand bits registered so each transaction moves as a unit.
// Optional unsigned saturation for ADD_SAT/SUB_SAT is enabled by defining
// ALU_ADD_PIPE_SAT_EN; without it those ops wrap like ADD/SUB.
module alu_add_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SEG = (WIDTH + STAGES - 1) / STAGES;
    localparam int unsigned L   = STAGES - 1;

    // Values entering each stage (from the ports for stage 0).
    logic             stg_v_in  [STAGES];
    op_t              stg_op_in [STAGES];
    logic [WIDTH-1:0] stg_a_in  [STAGES];
    logic [WIDTH-1:0] stg_b_in  [STAGES];  // already inverted for subtraction
    logic [WIDTH-1:0] stg_s_in  [STAGES];
    logic             stg_c_in  [STAGES];

    // Partial sum and carry after this stage's segment.
    logic [WIDTH-1:0] stg_s_d [STAGES];
    logic             stg_c_d [STAGES];

    // Pipeline registers.
    logic             valid_q [STAGES];
    op_t              op_q    [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];

    logic             advance;
    logic [WIDTH-1:0] raw_sum;
    logic             raw_ovf;
    logic [WIDTH-1:0] res_final;

    assign out_valid = valid_q[L];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // Feed each stage from the ports or from the previous stage's registers.
    always_comb begin
        stg_v_in[0]  = in_valid;
        stg_op_in[0] = op;
        stg_a_in[0]  = operand_a;
        stg_b_in[0]  = op_is_sub(op) ? ~operand_b : operand_b;
        stg_s_in[0]  = '0;
        stg_c_in[0]  = op_is_sub(op);
        for (int s = 1; s < STAGES; s++) begin
            stg_v_in[s]  = valid_q[s-1];
            stg_op_in[s] = op_q[s-1];
            stg_a_in[s]  = a_q[s-1];
            stg_b_in[s]  = b_q[s-1];
            stg_s_in[s]  = sum_q[s-1];
            stg_c_in[s]  = carry_q[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned SW = seg_width(WIDTH, STAGES, s);
        if (SW > 0) begin : g_add
            localparam int unsigned      LO   = s * SEG;
            localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << LO;
            logic [SW-1:0] seg_sum;
            logic          seg_cout;

            alu_add_seg #(
                .W (SW)
            ) u_seg (
                .a    (stg_a_in[s][LO +: SW]),
                .b    (stg_b_in[s][LO +: SW]),
                .cin  (stg_c_in[s]),
                .sum  (seg_sum),
                .cout (seg_cout)
            );

            assign stg_s_d[s] = (stg_s_in[s] & ~MASK) | (WIDTH'(seg_sum) << LO);
            assign stg_c_d[s] = seg_cout;
        end else begin : g_pass
            // Segment has no bits left; the stage only adds latency.
            assign stg_s_d[s] = stg_s_in[s];
            assign stg_c_d[s] = stg_c_in[s];
        end
    end

    // Whole pipeline advances together; a cycle without an accepted input
    // loads a bubble into stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                op_q[s]    <= OP_ADD;
                a_q[s]     <= '0;
                b_q[s]     <= '0;
                sum_q[s]   <= '0;
                carry_q[s] <= 1'b0;
            end
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= stg_v_in[s];
                op_q[s]    <= stg_op_in[s];
                a_q[s]     <= stg_a_in[s];
                b_q[s]     <= stg_b_in[s];
                sum_q[s]   <= stg_s_d[s];
                carry_q[s] <= stg_c_d[s];
            end
        end
    end

    // Signed overflow: operands agree in sign but the raw sum does not.
    always_comb begin
        raw_sum = sum_q[L];
        raw_ovf = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (raw_sum[WIDTH-1] != a_q[L][WIDTH-1]);
    end

`ifdef ALU_ADD_PIPE_SAT_EN
    // Unsigned clamp on the final stage output.
    always_comb begin
        res_final = raw_sum;
        if (op_q[L] == OP_ADD_SAT && carry_q[L]) begin
            res_final = '1;
        end else if (op_q[L] == OP_SUB_SAT && !carry_q[L]) begin
            res_final = '0;
        end
    end
`else
    assign res_final = raw_sum;

    // The op travels with the data but only the saturation logic consumes it.
    logic unused_op;
    assign unused_op = ^op_q[L];
`endif

    // Outputs read as zero whenever nothing is being presented.
    always_comb begin
        result    = out_valid ? res_final : '0;
        carry_out = out_valid & carry_q[L];
        overflow  = out_valid & raw_ovf;
        zero      = out_valid & (res_final == '0);
    end

endmodule

// File: tb/tb_alu_add_pipe.sv
// Scoreboard bench for alu_add_pipe: three instances (STAGES 1, 4, 5) share
// one stimulus stream; each has its own expected-response queue filled on
// acceptance and drained by a monitor on delivery.
module tb_alu_add_pipe;
    import alu_pkg::*;

    localparam int unsigned W = 5;
    localparam int          N = 3;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

`ifdef ALU_ADD_PIPE_SAT_EN
    localparam int ADDSAT_R = 31;
    localparam int ADDSAT_Z = 0;
    localparam int SUBSAT_R = 0;
    localparam int SUBSAT_Z = 1;
`else
    localparam int ADDSAT_R = 8;
    localparam int ADDSAT_Z = 0;
    localparam int SUBSAT_R = 30;
    localparam int SUBSAT_Z = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         cur_exp;

    logic         ir  [N];
    logic         ov  [N];
    logic         co  [N];
    logic         vf  [N];
    logic         zf  [N];
    logic [W-1:0] res [N];

    int   st_of [N];
    exp_t sb [N][64];
    int   wr [N];
    int   rd [N];
    int   dcnt [N];
    int   total;
    int   bad;
    int   cyc;
    logic arm;
    int   first_out [N];
    int   last_out [N];
    int   burst_cnt [N];

    alu_add_pipe #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .op(op),
        .operand_a(a), .operand_b(b), .out_valid(ov[0]), .out_ready(out_ready),
        .result(res[0]), .carry_out(co[0]), .overflow(vf[0]), .zero(zf[0])
    );

    alu_add_pipe #(.WIDTH(W), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .op(op),
        .operand_a(a), .operand_b(b), .out_valid(ov[1]), .out_ready(out_ready),
        .result(res[1]), .carry_out(co[1]), .overflow(vf[1]), .zero(zf[1])
    );

    alu_add_pipe #(.WIDTH(W), .STAGES(5)) u_s5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .op(op),
        .operand_a(a), .operand_b(b), .out_valid(ov[2]), .out_ready(out_ready),
        .result(res[2]), .carry_out(co[2]), .overflow(vf[2]), .zero(zf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d required %0d", name, k, act, exp);
        end
    endtask

    // Monitor: push on accept, pop and compare on delivery.
    initial begin
        exp_t got;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (rst_n && in_valid && ir[k]) begin
                    sb[k][wr[k] % 64] = cur_exp;
                    wr[k]++;
                end
                if (rst_n && ov[k] && out_ready) begin
                    got = '{r: res[k], c: co[k], v: vf[k], z: zf[k]};
                    dcnt[k]++;
                    total++;
                    if (rd[k] == wr[k]) begin
                        bad++;
                        $display("FAIL out_unexpected dut%0d: got r=%0d, required no output",
                                 k, got.r);
                    end else begin
                        e = sb[k][rd[k] % 64];
                        rd[k]++;
                        if (got !== e) begin
                            bad++;
                            $display("FAIL out_data dut%0d: got r=%0d c=%0d v=%0d z=%0d required r=%0d c=%0d v=%0d z=%0d",
                                     k, got.r, got.c, got.v, got.z, e.r, e.c, e.v, e.z);
                        end
                    end
                    if (arm) begin
                        if (first_out[k] < 0) first_out[k] = cyc;
                        last_out[k] = cyc;
                        burst_cnt[k]++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_t o, input int x, input int y,
                        input int r, input int c, input int v, input int z);
        in_valid  = 1'b1;
        op        = o;
        a         = W'(x);
        b         = W'(y);
        cur_exp.r = W'(r);
        cur_exp.c = 1'(c);
        cur_exp.v = 1'(v);
        cur_exp.z = 1'(z);
        step();
        in_valid  = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been delivered.
    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (rd[0] == wr[0] && rd[1] == wr[1] && rd[2] == wr[2]) break;
            step();
        end
        for (int k = 0; k < N; k++) chk(name, k, rd[k], wr[k]);
    endtask

    initial begin
        logic [W+3:0] snap [N];
        int first_acc;
        int dbase [N];

        st_of = '{1, 4, 5};
        total = 0;
        bad = 0;
        arm = 1'b0;
        for (int k = 0; k < N; k++) begin
            wr[k] = 0;
            rd[k] = 0;
            dcnt[k] = 0;
            first_out[k] = -1;
            last_out[k] = -1;
            burst_cnt[k] = 0;
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = OP_ADD;
        a = '0;
        b = '0;
        cur_exp = '0;

        #3;
        for (int k = 0; k < N; k++) begin
            chk("rst_out_valid", k, ov[k], 0);
            chk("rst_in_ready", k, ir[k], 1);
            chk("rst_outputs", k, {res[k], co[k], vf[k], zf[k]}, 0);
        end
        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed vectors, back to back.
        send(OP_ADD,      31,  1,  0, 1, 0, 1);
        send(OP_SUB,       3,  5, 30, 0, 0, 0);
        send(OP_SUB,      16,  1, 15, 1, 1, 0);
        send(OP_ADD_SAT,  20, 20, ADDSAT_R, 1, 1, ADDSAT_Z);
        send(OP_SUB_SAT,   3,  5, SUBSAT_R, 0, 0, SUBSAT_Z);
        send(OP_ADD,       7,  8, 15, 0, 0, 0);
        send(OP_ADD,      15,  1, 16, 0, 1, 0);
        send(OP_SUB,       5,  5,  0, 1, 0, 1);
        send(OP_SUB,       0,  1, 31, 0, 0, 0);
        send(OP_ADD,      16, 16,  0, 1, 1, 1);
        send(OP_SUB_SAT,   5,  3,  2, 1, 0, 0);
        send(OP_ADD_SAT,  10,  5, 15, 0, 0, 0);
        drain("drain_directed");
        step();
        for (int k = 0; k < N; k++) begin
            chk("idle_out_valid", k, ov[k], 0);
            chk("idle_outputs", k, {res[k], co[k], vf[k], zf[k]}, 0);
        end

        // Full-throughput burst: latency and one result per cycle.
        arm = 1'b1;
        first_acc = cyc;
        send(OP_ADD, 13,  9, 22, 0, 1, 0);
        send(OP_SUB, 22,  7, 15, 1, 1, 0);
        send(OP_ADD, 25,  6, 31, 0, 0, 0);
        send(OP_SUB,  4, 12, 24, 0, 0, 0);
        send(OP_ADD, 17, 30, 15, 1, 1, 0);
        send(OP_SUB,  9,  9,  0, 1, 0, 1);
        send(OP_ADD,  2,  3,  5, 0, 0, 0);
        send(OP_SUB, 31, 16, 15, 1, 0, 0);
        drain("drain_burst");
        arm = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("burst_latency", k, first_out[k] - first_acc, st_of[k]);
            chk("burst_span", k, last_out[k] - first_out[k], 7);
            chk("burst_count", k, burst_cnt[k], 8);
        end

        // Backpressure with the deepest pipeline full.
        send(OP_ADD,  1, 2,  3, 0, 0, 0);
        send(OP_ADD,  4, 4,  8, 0, 0, 0);
        send(OP_SUB,  9, 2,  7, 1, 0, 0);
        send(OP_ADD,  6, 6, 12, 0, 0, 0);
        send(OP_SUB, 10, 1,  9, 1, 0, 0);
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                chk("stall_in_ready", k, ir[k], 0);
                chk("stall_out_valid", k, ov[k], 1);
                if (t == 0) begin
                    snap[k] = {res[k], co[k], vf[k], zf[k], ov[k]};
                end else begin
                    chk("stall_stable", k, {res[k], co[k], vf[k], zf[k], ov[k]}, snap[k]);
                end
            end
        end
        step();
        out_ready = 1'b1;
        drain("drain_stall");

        // Reset with three transactions in flight.
        send(OP_ADD, 1, 1, 2, 0, 0, 0);
        send(OP_ADD, 2, 2, 4, 0, 0, 0);
        send(OP_ADD, 3, 3, 6, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("midrst_out_valid", k, ov[k], 0);
            chk("midrst_result", k, res[k], 0);
            chk("midrst_in_ready", k, ir[k], 1);
            rd[k] = wr[k];
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < N; k++) dbase[k] = dcnt[k];
        send(OP_SUB, 20, 6, 14, 1, 1, 0);
        drain("drain_post_reset");
        repeat (8) step();
        for (int k = 0; k < N; k++) chk("post_reset_deliveries", k, dcnt[k] - dbase[k], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_add_pipe.md
ALU_ADD_PIPE -- requirements
Module: alu_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/result width in bits (legal 2..64).
REQ-002 SHALL have parameter STAGES, default 1, number of pipeline register stages on the carry chain (legal 1..WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands and op valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a transaction this cycle.
REQ-007 SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 ADD_SAT, 11 SUB_SAT.
REQ-008 SHALL have port operand_a  input  WIDTH  first operand.
REQ-009 SHALL have port operand_b  input  WIDTH  second operand.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port result  output  WIDTH  arithmetic result.
REQ-013 SHALL have port carry_out  output  1  carry from MSB (SUB: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow.
REQ-015 SHALL have port zero  output  1  result equals 0.

Function
REQ-016 SHALL compute ADD as a+b and SUB as a+~b+1, modulo 2^WIDTH.
REQ-017 SHALL split the carry chain into STAGES segments of SEG=ceil(WIDTH/STAGES) bits (last segment holds the remainder), one segment resolved per stage, inter-segment carry registered.
REQ-018 SHALL register unresolved operand bits and op alongside each stage so a transaction advances as a unit.
REQ-019 SHALL have latency exactly STAGES cycles from accepted input to out_valid, with no bubbles at full throughput (one transaction per cycle).
REQ-020 SHALL accept a transaction when in_valid and in_ready are both high; SHALL deliver when out_valid and out_ready are both high.
REQ-021 SHALL advance the whole pipeline when advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational from out_ready).
REQ-022 SHALL hold result, flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL insert a bubble (stage valid=0) when advancing without an accepted input; bubbles SHALL never assert out_valid.
REQ-024 SHALL compute carry_out, overflow and zero from the final wrapped or saturated value as follows: carry_out and overflow from the raw sum; zero from the delivered result.
REQ-025 SHALL drive result, carry_out, overflow, zero to 0 whenever out_valid=0.

Reset
REQ-026 SHALL, on rst_n low, immediately clear all stage valid bits and data registers; out_valid=0, result=0, all flags=0.
REQ-027 SHALL discard in-flight transactions on reset mid-operation; first accept after release SHALL be the first delivered.
REQ-028 SHALL have in_ready=1 during and immediately after reset (pipeline empty).

Configuration
REQ-029 SHALL, with macro ALU_ADD_PIPE_SAT_EN defined, clamp ADD_SAT to 2^WIDTH-1 when carry_out=1 and SUB_SAT to 0 when carry_out=0 (unsigned saturation, applied in last stage, no added latency).
REQ-030 SHALL, without ALU_ADD_PIPE_SAT_EN, treat op 10 as ADD and op 11 as SUB (wrap-around), with no saturation logic synthesised.

Structure
REQ-031 SHALL place op encoding constants (OP_ADD, OP_SUB, OP_ADD_SAT, OP_SUB_SAT) and the 2-bit op typedef in shared package alu_pkg.
REQ-032 SHALL implement each segment in sub-module alu_add_seg (parametrised ripple adder: a, b, cin, sum, cout), instantiated STAGES times by generate.

Verification
REQ-033 SHALL cover WIDTH=5, STAGES=1: ADD 31+1 -> result 0, carry_out 1, zero 1, overflow 0 after 1 cycle.
REQ-034 SHALL cover WIDTH=5: SUB 3-5 -> result 30, carry_out 0, overflow 0; SUB 16-1 (-16-1) -> result 15, overflow 1.
REQ-035 SHALL cover ALU_ADD_PIPE_SAT_EN defined, WIDTH=5: ADD_SAT 20+20 -> 31; SUB_SAT 3-5 -> 0; same ops undefined -> 8 and 30.
REQ-036 SHALL cover WIDTH=5, STAGES=5: back-to-back 8 random transactions -> results in order, first out_valid exactly 5 cycles after first accept, then one per cycle.
REQ-037 SHALL cover backpressure: hold out_ready=0 for 3 cycles with pipeline full -> in_ready=0, outputs stable, no loss or duplication on release.
REQ-038 SHALL cover reset mid-operation: assert rst_n=0 with 3 in flight (STAGES=4) -> out_valid=0 immediately, none of the 3 ever delivered.
